term_sum_sequencer: RTL and testbench

- Sequencer directly downstream of the per-term postfix evaluator.
- Launches the evaluator once per term and collects each term result.
- Accumulates the terms into a single IEEE-754 single-precision sum, using the shared floating-point adder through the start/ready handshake.
- Presents the final sum with a one-cycle ready pulse to the polynomial-level controller.

---
 rtl/term_sum_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_term_sum_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/term_sum_sequencer.sv
// Sums a run of per-term evaluator results into one single-precision value
// through the shared adder. Outputs are one-cycle registered images of the FSM state.
module term_sum_sequencer #(
    parameter  int DATA_WIDTH     = 32,
    parameter  int MAX_TERMS      = 16,
    parameter  int TIMEOUT_CYCLES = 4096,
    localparam int TERM_IDX_WIDTH = $clog2(MAX_TERMS + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      sum_start,
    input  logic [TERM_IDX_WIDTH-1:0] num_terms,
    output logic                      term_start,
    output logic [TERM_IDX_WIDTH-1:0] term_index,
    input  logic [DATA_WIDTH-1:0]     term_value,
    input  logic                      term_ready,
    output logic                      add_start,
    output logic [DATA_WIDTH-1:0]     add_operand_a,
    output logic [DATA_WIDTH-1:0]     add_operand_b,
    input  logic [DATA_WIDTH-1:0]     add_result,
    input  logic                      add_data_ready,
    output logic [DATA_WIDTH-1:0]     sum_value,
    output logic                      sum_ready,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int WAIT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_WIDTH-1:0]     WAIT_MAX  = WAIT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [TERM_IDX_WIDTH-1:0] MAX_COUNT = TERM_IDX_WIDTH'(MAX_TERMS);
    localparam logic [TERM_IDX_WIDTH-1:0] IDX_ONE   = TERM_IDX_WIDTH'(1);
    localparam logic [TERM_IDX_WIDTH-1:0] IDX_ZERO  = TERM_IDX_WIDTH'(0);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_TERM = 3'd2,
        ADD       = 3'd3,
        WAIT_ADD  = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [DATA_WIDTH-1:0]     r_acc,        w_acc_next;
    logic [DATA_WIDTH-1:0]     r_term_reg,   w_term_reg_next;
    logic [TERM_IDX_WIDTH-1:0] r_index,      w_index_next;
    logic [TERM_IDX_WIDTH-1:0] r_count,      w_count_next;
    logic [WAIT_WIDTH-1:0]     r_wait_cnt,   w_wait_next;
    logic                      r_timeout_err, w_timeout_next;
    logic [TERM_IDX_WIDTH-1:0] w_clamped;
    logic                      w_last;

    logic                      r_term_start;
    logic [TERM_IDX_WIDTH-1:0] r_term_index;
    logic                      r_add_start;
    logic [DATA_WIDTH-1:0]     r_sum_value;
    logic                      r_sum_ready;
    logic                      r_busy;

    assign w_clamped = (num_terms > MAX_COUNT) ? MAX_COUNT : num_terms;
    assign w_last    = ((r_index + IDX_ONE) == r_count);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        w_state_next    = r_state;
        w_acc_next      = r_acc;
        w_term_reg_next = r_term_reg;
        w_index_next    = r_index;
        w_count_next    = r_count;
        w_wait_next     = r_wait_cnt;
        w_timeout_next  = r_timeout_err;
        case (r_state)
            IDLE: begin
                if (sum_start) begin
                    w_count_next   = w_clamped;
                    w_index_next   = IDX_ZERO;
                    w_acc_next     = '0;
                    w_timeout_next = 1'b0;
                    w_state_next   = (w_clamped == IDX_ZERO) ? DONE : LAUNCH;
                end else begin
                    w_state_next = IDLE;
                end
            end
            LAUNCH: begin
                w_wait_next  = '0;
                w_state_next = WAIT_TERM;
            end
            WAIT_TERM: begin
                if (term_ready) begin
                    w_term_reg_next = term_value;
                    // The first term seeds the accumulator without an adder pass.
                    if (r_index == IDX_ZERO) begin
                        w_acc_next   = term_value;
                        w_index_next = r_index + IDX_ONE;
                        w_state_next = w_last ? DONE : LAUNCH;
                    end else begin
                        w_state_next = ADD;
                    end
                end else if (r_wait_cnt == WAIT_MAX) begin
                    w_timeout_next = 1'b1;
                    w_state_next   = IDLE;
                end else begin
                    w_wait_next = r_wait_cnt + WAIT_WIDTH'(1);
                end
            end
            ADD: begin
                w_wait_next  = '0;
                w_state_next = WAIT_ADD;
            end
            WAIT_ADD: begin
                if (add_data_ready) begin
                    w_acc_next   = add_result;
                    w_index_next = r_index + IDX_ONE;
                    w_state_next = w_last ? DONE : LAUNCH;
                end else if (r_wait_cnt == WAIT_MAX) begin
                    w_timeout_next = 1'b1;
                    w_state_next   = IDLE;
                end else begin
                    w_wait_next = r_wait_cnt + WAIT_WIDTH'(1);
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_acc         <= '0;
            r_term_reg    <= '0;
            r_index       <= '0;
            r_count       <= '0;
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
            r_term_start  <= 1'b0;
            r_term_index  <= '0;
            r_add_start   <= 1'b0;
            r_sum_value   <= '0;
            r_sum_ready   <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_acc         <= w_acc_next;
            r_term_reg    <= w_term_reg_next;
            r_index       <= w_index_next;
            r_count       <= w_count_next;
            r_wait_cnt    <= w_wait_next;
            r_timeout_err <= w_timeout_next;
            r_term_start  <= (r_state == LAUNCH);
            r_term_index  <= (r_state == LAUNCH) ? r_index : r_term_index;
            r_add_start   <= (r_state == ADD);
            r_sum_value   <= (r_state == DONE) ? r_acc : r_sum_value;
            r_sum_ready   <= (r_state == DONE);
            // Busy also spans the cycle that carries the sum_ready pulse.
            r_busy        <= (w_state_next != IDLE) || (r_state == DONE);
        end
    end

    assign term_start    = r_term_start;
    assign term_index    = r_term_index;
    assign add_start     = r_add_start;
    assign add_operand_a = r_acc;
    assign add_operand_b = r_term_reg;
    assign sum_value     = r_sum_value;
    assign sum_ready     = r_sum_ready;
    assign busy          = r_busy;
    assign timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_term_sum_sequencer.sv
// Directed bench for term_sum_sequencer with a term-evaluator model and a
// table-driven 5-cycle adder model.
module tb_term_sum_sequencer;

    localparam int DW  = 32;
    localparam int TIW = $clog2(16 + 1);

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           main_start = 1'b0;
    logic           inj_start  = 1'b0;
    logic           sum_start;
    logic [TIW-1:0] num_terms = '0;
    logic           term_start;
    logic [TIW-1:0] term_index;
    logic [DW-1:0]  term_value = '0;
    logic           term_ready = 1'b0;
    logic           add_start;
    logic [DW-1:0]  add_operand_a, add_operand_b;
    logic [DW-1:0]  add_result;
    logic           add_data_ready;
    logic [DW-1:0]  sum_value;
    logic           sum_ready;
    logic           busy;
    logic           timeout_err;

    logic           mdl_ready = 1'b0;
    logic [DW-1:0]  mdl_res   = '0;
    logic           spur_ready = 1'b0;
    logic [DW-1:0]  spur_res   = '0;

    assign sum_start      = main_start | inj_start;
    assign add_data_ready = mdl_ready | spur_ready;
    assign add_result     = mdl_res | spur_res;

    term_sum_sequencer #(
        .DATA_WIDTH(32), .MAX_TERMS(16), .TIMEOUT_CYCLES(16)
    ) dut (
        .clock(clock), .reset(reset), .sum_start(sum_start), .num_terms(num_terms),
        .term_start(term_start), .term_index(term_index), .term_value(term_value),
        .term_ready(term_ready), .add_start(add_start), .add_operand_a(add_operand_a),
        .add_operand_b(add_operand_b), .add_result(add_result),
        .add_data_ready(add_data_ready), .sum_value(sum_value), .sum_ready(sum_ready),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;
    logic [DW-1:0] term_tab [4];
    bit term_en = 1'b1;
    bit inject  = 1'b0;

    int ts_cnt = 0;
    int as_cnt = 0;
    int sr_cnt = 0;
    logic [TIW-1:0] ts_idx [64];

    // Pulse monitor
    always @(negedge clock) begin
        if (term_start) begin
            ts_idx[ts_cnt % 64] <= term_index;
            ts_cnt <= ts_cnt + 1;
        end
        if (add_start) as_cnt <= as_cnt + 1;
        if (sum_ready) sr_cnt <= sr_cnt + 1;
    end

    // Term evaluator model: answers two cycles after term_start, zero otherwise
    initial begin
        logic [TIW-1:0] idx;
        forever begin
            @(negedge clock);
            if (term_start && term_en) begin
                idx = term_index;
                repeat (2) @(negedge clock);
                term_ready = 1'b1;
                term_value = term_tab[idx[1:0]];
                @(negedge clock);
                term_ready = 1'b0;
                term_value = '0;
            end
        end
    end

    function automatic logic [DW-1:0] fadd(input logic [DW-1:0] a, input logic [DW-1:0] b);
        case ({a, b})
            {32'h3F800000, 32'h40000000}: fadd = 32'h40400000;
            {32'h40400000, 32'h40400000}: fadd = 32'h40C00000;
            default:                      fadd = 32'hDEADBEEF;
        endcase
    endfunction

    // Adder model: result five cycles after add_start
    initial begin
        logic [DW-1:0] a, b;
        forever begin
            @(negedge clock);
            if (add_start) begin
                a = add_operand_a;
                b = add_operand_b;
                repeat (5) @(negedge clock);
                mdl_ready = 1'b1;
                mdl_res   = fadd(a, b);
                @(negedge clock);
                mdl_ready = 1'b0;
                mdl_res   = '0;
            end
        end
    end

    // Injects a busy-time sum_start and a stray adder strobe while waiting for term 1
    initial begin
        forever begin
            @(negedge clock);
            if (inject && term_start && term_index == 5'd1) begin
                inj_start  = 1'b1;
                spur_ready = 1'b1;
                spur_res   = 32'h12345678;
                @(negedge clock);
                inj_start  = 1'b0;
                spur_ready = 1'b0;
                spur_res   = '0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_eval(input logic [TIW-1:0] n, input string tag, input logic [DW-1:0] exp_sum,
                            input int exp_terms, input int exp_adds, input int exp_lat);
        int ts0, as0, sr0, cyc;
        bit seen;
        ts0 = ts_cnt; as0 = as_cnt; sr0 = sr_cnt;
        num_terms  = n;
        main_start = 1'b1;
        @(negedge clock);
        main_start = 1'b0;
        check({tag, "_toerr_clr"}, 32'(timeout_err), 32'd0);
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc < 400) begin
            if (sum_ready) seen = 1'b1;
            else begin
                @(negedge clock);
                cyc++;
            end
        end
        check({tag, "_ready_seen"}, 32'(seen), 32'd1);
        if (exp_lat > 0) check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_sum"}, sum_value, exp_sum);
        check({tag, "_busy_at_ready"}, 32'(busy), 32'd1);
        @(negedge clock);
        check({tag, "_ready_pulse"}, 32'(sum_ready), 32'd0);
        check({tag, "_busy_drop"}, 32'(busy), 32'd0);
        check({tag, "_term_starts"}, 32'(ts_cnt - ts0), 32'(exp_terms));
        check({tag, "_add_starts"}, 32'(as_cnt - as0), 32'(exp_adds));
        check({tag, "_sum_readys"}, 32'(sr_cnt - sr0), 32'd1);
        for (int i = 0; i < exp_terms; i++)
            check({tag, "_term_idx"}, 32'(ts_idx[(ts0 + i) % 64]), 32'(i));
    endtask

    initial begin
        int k, sr0;
        bit hit;
        term_tab[0] = 32'h3F800000;
        term_tab[1] = 32'h40000000;
        term_tab[2] = 32'h40400000;
        term_tab[3] = 32'h00000000;

        #3 reset = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sum", sum_value, 32'd0);
        check("rst_strobes", {29'd0, term_start, add_start, sum_ready}, 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // 1: three terms, 1+2+3
        run_eval(5'd3, "s1", 32'h40C00000, 3, 2, 0);

        // 2: single term passes straight through
        term_tab[0] = 32'hC0490FDB;
        run_eval(5'd1, "s2", 32'hC0490FDB, 1, 0, 0);
        term_tab[0] = 32'h3F800000;

        // 3: zero terms
        run_eval(5'd0, "s3", 32'h00000000, 0, 0, 2);

        // 4: busy sum_start and stray adder strobe are ignored
        inject = 1'b1;
        run_eval(5'd3, "s4", 32'h40C00000, 3, 2, 0);
        inject = 1'b0;
        repeat (3) @(negedge clock);
        check("s4_no_requeue", 32'(busy), 32'd0);

        // 5: evaluator never answers
        term_en = 1'b0;
        sr0 = sr_cnt;
        num_terms  = 5'd3;
        main_start = 1'b1;
        @(negedge clock);
        main_start = 1'b0;
        k = 0;
        while (!term_start && k < 10) begin
            @(negedge clock);
            k++;
        end
        check("s5_term_start", 32'(term_start), 32'd1);
        k = 0;
        while (!timeout_err && k < 40) begin
            @(negedge clock);
            k++;
        end
        check("s5_timeout_set", 32'(timeout_err), 32'd1);
        check("s5_timeout_bound", 32'(k <= 16), 32'd1);
        check("s5_idle", 32'(busy), 32'd0);
        check("s5_sum_kept", sum_value, 32'h40C00000);
        @(negedge clock);
        check("s5_no_ready", 32'(sr_cnt - sr0), 32'd0);
        check("s5_sticky", 32'(timeout_err), 32'd1);
        term_en = 1'b1;
        run_eval(5'd3, "s5b", 32'h40C00000, 3, 2, 0);

        // 6: reset during WAIT_ADD
        sr0 = sr_cnt;
        num_terms  = 5'd3;
        main_start = 1'b1;
        @(negedge clock);
        main_start = 1'b0;
        hit = 1'b0;
        k = 0;
        while (!hit && k < 60) begin
            if (add_start) hit = 1'b1;
            else begin
                @(negedge clock);
                k++;
            end
        end
        check("s6_add_seen", 32'(hit), 32'd1);
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("s6_rst_sum", sum_value, 32'd0);
        check("s6_rst_busy", 32'(busy), 32'd0);
        check("s6_rst_opa", add_operand_a, 32'd0);
        check("s6_rst_opb", add_operand_b, 32'd0);
        check("s6_rst_misc", {24'd0, term_index, term_start, add_start, sum_ready}, 32'd0);
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("s6_no_ready", 32'(sr_cnt - sr0), 32'd0);
        run_eval(5'd3, "s6b", 32'h40C00000, 3, 2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
